// File: rtl/spi_frame_arbiter.sv
// Round-robin frame arbiter feeding one SPI master byte engine.
// Optional per-byte timeout with abort: define SPI_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_frame_arbiter #(
    parameter int CLK_DIV  = 6,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2,
    parameter int SS_GAP   = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [7:0] data0_i,
    input  logic       last0_i,
    input  logic [7:0] data1_i,
    input  logic       last1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] byte_rd_o,
    input  logic       busy_spi,
    output logic       spi_send,
    output logic [7:0] data_spi,
    output logic       ena_2clk,
    output logic       spi_ss_n,
    output logic       err_o
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = 8;

    if (CLK_DIV < 2 || TIMEOUT < 1 || SS_SETUP > 255 ||
        SS_HOLD > 255 || SS_GAP > 255) begin : g_param_check
        $error("spi_frame_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE, SETUP, SEND, WAIT_HI, WAIT_LO, HOLD, GAP
    } state_t;

    state_t        state;
    logic [DW-1:0] div_q;
    logic [TW-1:0] tick_q;
    logic          sel_q;
    logic          rr_q;
    logic          last_q;
    logic          pick;
    logic          tout_hit;

    // Free-running divider; the FSM never resets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            ena_2clk <= 1'b0;
        end else begin
            if (div_q == DW'(CLK_DIV - 1))
                div_q <= '0;
            else
                div_q <= div_q + 1'b1;
            ena_2clk <= (div_q == DW'(CLK_DIV - 2));
        end
    end

    // rr_q holds the last requester served.
    assign pick = (req_i[0] & req_i[1]) ? ~rr_q : req_i[1];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT + 1);
    logic [OW-1:0] tout_q;

    assign tout_hit = (tout_q == OW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tout_q <= '0;
            err_o  <= 1'b0;
        end else if (state == SEND) begin
            tout_q <= '0;
        end else if (state == WAIT_HI || state == WAIT_LO) begin
            if (tout_hit)
                err_o <= 1'b1;
            else
                tout_q <= tout_q + 1'b1;
        end
    end
`else
    assign tout_hit = 1'b0;
    assign err_o    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_o     <= '0;
            byte_rd_o <= '0;
            spi_send  <= 1'b0;
            data_spi  <= '0;
            spi_ss_n  <= 1'b1;
            sel_q     <= 1'b0;
            rr_q      <= 1'b1;
            last_q    <= 1'b0;
            tick_q    <= '0;
        end else begin
            spi_send  <= 1'b0;
            byte_rd_o <= '0;
            unique case (state)
                IDLE: begin
                    if (|req_i) begin
                        sel_q    <= pick;
                        gnt_o    <= pick ? 2'b10 : 2'b01;
                        spi_ss_n <= 1'b0;
                        tick_q   <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick_q == TW'(SS_SETUP))
                        state <= SEND;
                    else if (ena_2clk)
                        tick_q <= tick_q + 1'b1;
                end
                SEND: begin
                    data_spi  <= sel_q ? data1_i : data0_i;
                    last_q    <= sel_q ? last1_i : last0_i;
                    byte_rd_o <= sel_q ? 2'b10 : 2'b01;
                    spi_send  <= 1'b1;
                    state     <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tout_hit) begin
                        tick_q <= '0;
                        state  <= HOLD;
                    end else if (busy_spi) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (tout_hit || (!busy_spi && last_q)) begin
                        tick_q <= '0;
                        state  <= HOLD;
                    end else if (!busy_spi) begin
                        state <= SEND;
                    end
                end
                HOLD: begin
                    if (tick_q == TW'(SS_HOLD)) begin
                        spi_ss_n <= 1'b1;
                        gnt_o    <= '0;
                        rr_q     <= sel_q;
                        tick_q   <= '0;
                        state    <= GAP;
                    end else if (ena_2clk) begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                GAP: begin
                    if (tick_q == TW'(SS_GAP))
                        state <= IDLE;
                    else if (ena_2clk)
                        tick_q <= tick_q + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench for spi_frame_arbiter with a simple SPI master
// and two frame-requester models; timeout scenario under SPI_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_spi_frame_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [7:0] data0_i = 8'h00;
    logic       last0_i = 1'b0;
    logic [7:0] data1_i = 8'h00;
    logic       last1_i = 1'b0;
    logic [1:0] gnt_o;
    logic [1:0] byte_rd_o;
    logic       busy_spi = 1'b0;
    logic       spi_send;
    logic [7:0] data_spi;
    logic       ena_2clk;
    logic       spi_ss_n;
    logic       err_o;

    always #5 clk = ~clk;

    spi_frame_arbiter #(
        .CLK_DIV(6), .SS_SETUP(2), .SS_HOLD(2), .SS_GAP(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i),
        .data0_i(data0_i), .last0_i(last0_i),
        .data1_i(data1_i), .last1_i(last1_i),
        .gnt_o(gnt_o), .byte_rd_o(byte_rd_o), .busy_spi(busy_spi),
        .spi_send(spi_send), .data_spi(data_spi), .ena_2clk(ena_2clk),
        .spi_ss_n(spi_ss_n), .err_o(err_o)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] frm0 [4];
    logic [7:0] frm1 [4];
    int len0 = 1, len1 = 1, idx0 = 0, idx1 = 0;

    logic [7:0] sent_q [$];
    logic [1:0] gnt_q  [$];
    int         gap_q  [$];
    int rd0 = 0, rd1 = 0;
    int hold_cnt = 0, last_hold = -1;
    bit hold_meas = 0;
    int gap_cnt = 0;
    bit in_gap = 0;
    bit prev_ss = 1;
    logic [1:0] prev_gnt = 2'b00;
    int frames_done = 0;
    int bcnt = 0;
    bit busy_stuck = 0;

    // Master model, requester models and monitors, all at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (hold_meas && spi_ss_n) begin
                last_hold = hold_cnt;
                hold_meas = 0;
            end else if (hold_meas && ena_2clk) begin
                hold_cnt++;
            end
            if (spi_ss_n && !prev_ss) begin
                in_gap = 1;
                gap_cnt = 0;
                frames_done++;
            end
            if (in_gap && spi_ss_n && ena_2clk) gap_cnt++;
            if (in_gap && !spi_ss_n) begin
                gap_q.push_back(gap_cnt);
                in_gap = 0;
            end
            prev_ss = spi_ss_n;
            if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_q.push_back(gnt_o);
            prev_gnt = gnt_o;
            if (spi_send) begin
                sent_q.push_back(data_spi);
                hold_meas = 0;
                busy_spi = 1'b1;
                bcnt = 8;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0 && !busy_stuck) begin
                    busy_spi = 1'b0;
                    hold_meas = 1;
                    hold_cnt = 0;
                end
            end
            if (byte_rd_o[0]) begin
                rd0++;
                idx0 = (idx0 == len0 - 1) ? 0 : idx0 + 1;
            end
            if (byte_rd_o[1]) begin
                rd1++;
                idx1 = (idx1 == len1 - 1) ? 0 : idx1 + 1;
            end
            data0_i = frm0[idx0];
            last0_i = (idx0 == len0 - 1);
            data1_i = frm1[idx1];
            last1_i = (idx1 == len1 - 1);
        end
    end

    task automatic clear_logs();
        sent_q.delete();
        gnt_q.delete();
        gap_q.delete();
        rd0 = 0;
        rd1 = 0;
        frames_done = 0;
        last_hold = -1;
        idx0 = 0;
        idx1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_frames(input int n, input string name);
        for (int i = 0; i < 3000 && frames_done < n; i++) @(negedge clk);
        if (frames_done < n) begin
            total++;
            $display("FAIL %s: frames=%0d want %0d (timeout)",
                     name, frames_done, n);
        end
    endtask

    task automatic wait_send(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (spi_send) break;
        end
        if (!spi_send) begin
            total++;
            $display("FAIL %s: no spi_send (timeout)", name);
        end
    endtask

    task automatic test_reset();
        total++;
        if (gnt_o !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt_o);
        else passed++;
        total++;
        if (byte_rd_o !== 2'b00) $display("FAIL rst_rd: got %b want 00", byte_rd_o);
        else passed++;
        total++;
        if (spi_send !== 1'b0) $display("FAIL rst_send: got %b want 0", spi_send);
        else passed++;
        total++;
        if (data_spi !== 8'h00) $display("FAIL rst_data: got %h want 00", data_spi);
        else passed++;
        total++;
        if (spi_ss_n !== 1'b1) $display("FAIL rst_ss: got %b want 1", spi_ss_n);
        else passed++;
        total++;
        if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o);
        else passed++;
        total++;
        if (ena_2clk !== 1'b0) $display("FAIL rst_ena: got %b want 0", ena_2clk);
        else passed++;
    endtask

    task automatic test_ena();
        int first = 0, cnt = 0, prev = 0, bad = 0;
        rst = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ena_2clk === 1'b1) begin
                if (first == 0) first = k;
                else if (k - prev != 6) bad++;
                prev = k;
                cnt++;
            end
        end
        total++;
        if (first != 5) $display("FAIL ena_first: got %0d want 5", first);
        else passed++;
        total++;
        if (cnt != 10) $display("FAIL ena_count: got %0d want 10", cnt);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL ena_spacing: bad=%0d want 0", bad);
        else passed++;
    endtask

    task automatic test_frame();
        logic [23:0] got = '0;
        logic [7:0] g = '0;
        do_reset();
        frm0[0] = 8'hA5; frm0[1] = 8'h3C; frm0[2] = 8'hFF; len0 = 3;
        req_i = 2'b01;
        wait_frames(1, "frame_wait");
        req_i = 2'b00;
        foreach (sent_q[i]) got = {got[15:0], sent_q[i]};
        foreach (gnt_q[i]) g = {g[5:0], gnt_q[i]};
        total++;
        if (sent_q.size() != 3) $display("FAIL frame_nsend: got %0d want 3", sent_q.size());
        else passed++;
        total++;
        if (got !== 24'hA53CFF) $display("FAIL frame_bytes: got %h want a53cff", got);
        else passed++;
        total++;
        if (rd0 != 3 || rd1 != 0) $display("FAIL frame_rd: got %0d/%0d want 3/0", rd0, rd1);
        else passed++;
        total++;
        if (gnt_q.size() != 1 || g !== 8'h01) $display("FAIL frame_gnt: got %h n=%0d want 01", g, gnt_q.size());
        else passed++;
        total++;
        if (last_hold != 2) $display("FAIL frame_hold: got %0d want 2", last_hold);
        else passed++;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_rr();
        logic [31:0] got = '0;
        logic [7:0] g = '0;
        int mn = 1000;
        do_reset();
        frm0[0] = 8'h11; len0 = 1;
        frm1[0] = 8'h22; len1 = 1;
        req_i = 2'b11;
        wait_frames(4, "rr_wait");
        req_i = 2'b00;
        foreach (sent_q[i]) if (i < 4) got = {got[23:0], sent_q[i]};
        foreach (gnt_q[i]) if (i < 4) g = {g[5:0], gnt_q[i]};
        foreach (gap_q[i]) if (gap_q[i] < mn) mn = gap_q[i];
        total++;
        if (g !== 8'b01100110) $display("FAIL rr_order: got %b want 01100110", g);
        else passed++;
        total++;
        if (got !== 32'h11221122) $display("FAIL rr_bytes: got %h want 11221122", got);
        else passed++;
        total++;
        if (gap_q.size() < 3) $display("FAIL rr_ngap: got %0d want >=3", gap_q.size());
        else passed++;
        total++;
        if (mn < 4) $display("FAIL rr_gap: got %0d want >=4", mn);
        else passed++;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_drop();
        logic [23:0] got = '0;
        logic [7:0] g = '0;
        do_reset();
        frm0[0] = 8'h41; frm0[1] = 8'h42; len0 = 2;
        frm1[0] = 8'h77; len1 = 1;
        req_i = 2'b01;
        for (int i = 0; i < 2000 && rd0 < 1; i++) @(negedge clk);
        req_i = 2'b10;
        wait_frames(2, "drop_wait");
        req_i = 2'b00;
        foreach (sent_q[i]) if (i < 3) got = {got[15:0], sent_q[i]};
        foreach (gnt_q[i]) if (i < 4) g = {g[5:0], gnt_q[i]};
        total++;
        if (sent_q.size() != 3) $display("FAIL drop_nsend: got %0d want 3", sent_q.size());
        else passed++;
        total++;
        if (got !== 24'h414277) $display("FAIL drop_bytes: got %h want 414277", got);
        else passed++;
        total++;
        if (g !== 8'b00000110) $display("FAIL drop_gnt: got %b want 00000110", g);
        else passed++;
        total++;
        if (rd0 != 2) $display("FAIL drop_rd0: got %0d want 2", rd0);
        else passed++;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] g = '0;
        do_reset();
        frm0[0] = 8'h55; frm0[1] = 8'h66; len0 = 2;
        req_i = 2'b01;
        wait_send("mid_send");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (spi_ss_n !== 1'b1) $display("FAIL mid_ss: got %b want 1", spi_ss_n);
        else passed++;
        total++;
        if (gnt_o !== 2'b00) $display("FAIL mid_gnt: got %b want 00", gnt_o);
        else passed++;
        total++;
        if (byte_rd_o !== 2'b00 || spi_send !== 1'b0)
            $display("FAIL mid_pulse: rd=%b send=%b want 00/0", byte_rd_o, spi_send);
        else passed++;
        total++;
        if (rd0 != 1) $display("FAIL mid_rdcount: got %0d want 1", rd0);
        else passed++;
        rst = 1'b0;
        req_i = 2'b00;
        repeat (15) @(negedge clk);
        clear_logs();
        frm0[0] = 8'h99; len0 = 1;
        req_i = 2'b01;
        wait_frames(1, "mid_restart");
        req_i = 2'b00;
        foreach (gnt_q[i]) if (i < 4) g = {g[5:0], gnt_q[i]};
        total++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'h99)
            $display("FAIL mid_restart_byte: n=%0d want 1 byte 99", sent_q.size());
        else passed++;
        total++;
        if (g !== 8'h01) $display("FAIL mid_restart_gnt: got %b want 01", g);
        else passed++;
        repeat (60) @(negedge clk);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        do_reset();
        frm0[0] = 8'hA1; len0 = 1;
        frm1[0] = 8'hB2; len1 = 1;
        busy_stuck = 1;
        req_i = 2'b11;
        wait_send("tout_send");
        total++;
        if (data_spi !== 8'hA1) $display("FAIL tout_first: got %h want a1", data_spi);
        else passed++;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (err_o === 1'b1) break;
        end
        total++;
        if (k != 64) $display("FAIL tout_latency: got %0d want 64", k);
        else passed++;
        wait_frames(1, "tout_release");
        total++;
        if (spi_ss_n !== 1'b1 || gnt_o !== 2'b00)
            $display("FAIL tout_release: ss=%b gnt=%b want 1/00", spi_ss_n, gnt_o);
        else passed++;
        busy_stuck = 0;
        busy_spi = 1'b0;
        for (int i = 0; i < 2000 && gnt_q.size() < 2; i++) @(negedge clk);
        req_i = 2'b00;
        total++;
        if (gnt_q.size() < 2 || gnt_q[1] !== 2'b10)
            $display("FAIL tout_next_gnt: n=%0d want second grant 10", gnt_q.size());
        else passed++;
        wait_frames(2, "tout_second");
        total++;
        if (err_o !== 1'b1) $display("FAIL tout_sticky: got %b want 1", err_o);
        else passed++;
    endtask
`else
    task automatic test_timeout();
        total++;
        if (err_o !== 1'b0) $display("FAIL err_tied: got %b want 0", err_o);
        else passed++;
    endtask
`endif

    initial begin
        frm0[0] = 8'h00; frm0[1] = 8'h00; frm0[2] = 8'h00; frm0[3] = 8'h00;
        frm1[0] = 8'h00; frm1[1] = 8'h00; frm1[2] = 8'h00; frm1[3] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_ena();
        test_frame();
        test_rr();
        test_drop();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
